// File: rtl/io_bus_pkg.sv
// io_bus_pkg: shared IO write-bus constants and requester-slice unpacking helper.
package io_bus_pkg;
  localparam logic [5:0] IO_PORT_BASE = 6'h20;
  localparam int IO_AW = 32;
  localparam int IO_DW = 32;
  // Widest supported slice is 64 bits across at most 8 requesters.
  function automatic logic [63:0] unpack(input logic [511:0] bus, input int idx, input int w);
    return 64'(bus >> (idx * w));
  endfunction
endpackage

// File: rtl/io_write_arbiter_if.sv
// io_write_arbiter_if: requester-side and output-register-side IO write bus signals.
interface io_write_arbiter_if import io_bus_pkg::*; #(
  parameter int NREQ = 4,
  parameter int AW = IO_AW,
  parameter int DW = IO_DW
) ();
  localparam int PW = $clog2(NREQ);
  logic [NREQ-1:0] req;
  logic [NREQ*AW-1:0] req_addr;
  logic [NREQ*DW-1:0] req_data;
  logic [NREQ-1:0] gnt;
  logic [AW-1:0] io_addr;
  logic [DW-1:0] io_datain;
  logic io_we;
  logic err;
  logic [PW-1:0] err_src;
  modport master (output req, req_addr, req_data, input gnt, io_addr, io_datain, io_we, err, err_src);
  modport slave (input req, req_addr, req_data, output gnt, io_addr, io_datain, io_we, err, err_src);
endinterface

// File: rtl/io_write_arbiter_rr_pick.sv
// rr_pick: combinational rotate-priority picker, first set bit at or after ptr with wrap.
module rr_pick #(
  parameter int N = 4,
  parameter int PW = $clog2(N)
) (
  input  logic [N-1:0]  elig_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  onehot_o,
  output logic [PW-1:0] idx_o,
  output logic          valid_o
);
  int j;
  always_comb begin
    onehot_o = '0;
    idx_o = '0;
    valid_o = 1'b0;
    j = 0;
    // Scan farthest offset first so the nearest eligible index overwrites.
    for (int i = N - 1; i >= 0; i--) begin
      j = (int'(ptr_i) + i >= N) ? int'(ptr_i) + i - N : int'(ptr_i) + i;
      if (elig_i[j]) begin
        onehot_o = '0;
        onehot_o[j] = 1'b1;
        idx_o = PW'(j);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/io_write_arbiter.sv
// io_write_arbiter: round-robin serialiser of NREQ requesters onto one registered IO write bus.
// Optional IO_WR_ADDR_CHECK_EN suppresses io_we for writes outside the output-port window and flags err.
module io_write_arbiter import io_bus_pkg::*; #(
  parameter int NREQ = 4,
  parameter int AW = IO_AW,
  parameter int DW = IO_DW,
  parameter int NPORT = 4
) (
  input logic io_clk,
  input logic clr,
  io_write_arbiter_if.slave bus
);
  localparam int PW = $clog2(NREQ);
  if (NREQ < 2 || NREQ > 8 || NPORT < 1 || NPORT > 64 || AW < 8 || AW > 64 || DW > 64) begin : g_bad_cfg
    $error("io_write_arbiter: unsupported parameter set");
  end
  logic [NREQ-1:0] gnt_q, gnt_d, elig, pick;
  logic [PW-1:0] ptr_q, ptr_d, idx;
  logic [AW-1:0] addr_q, addr_d, win_addr;
  logic [DW-1:0] data_q, data_d, win_data;
  logic we_q, we_d, vld, ok;
  rr_pick #(.N(NREQ)) u_pick (.elig_i(elig), .ptr_i(ptr_q), .onehot_o(pick), .idx_o(idx), .valid_o(vld));
  // Last cycle's winner sits out one cycle so it can drop or advance its request.
  always_comb begin
    elig = bus.req & ~gnt_q;
    win_addr = AW'(unpack(512'(bus.req_addr), int'(idx), AW));
    win_data = DW'(unpack(512'(bus.req_data), int'(idx), DW));
    gnt_d = vld ? pick : '0;
    we_d = vld & ok;
    addr_d = vld ? win_addr : addr_q;
    data_d = vld ? win_data : data_q;
    ptr_d = vld ? ((idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1) : ptr_q;
  end
  always_ff @(posedge io_clk) begin
    if (clr) begin
      gnt_q <= '0;
      we_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ptr_q <= '0;
    end else begin
      gnt_q <= gnt_d;
      we_q <= we_d;
      addr_q <= addr_d;
      data_q <= data_d;
      ptr_q <= ptr_d;
    end
  end
`ifdef IO_WR_ADDR_CHECK_EN
  logic err_q, err_d;
  logic [PW-1:0] err_src_q, err_src_d;
  always_comb begin
    ok = win_addr[7:2] >= IO_PORT_BASE && win_addr[7:2] <= IO_PORT_BASE + 6'(NPORT - 1);
    err_d = err_q | (vld & ~ok);
    err_src_d = (vld & ~ok & ~err_q) ? idx : err_src_q;
  end
  always_ff @(posedge io_clk) begin
    if (clr) begin
      err_q <= 1'b0;
      err_src_q <= '0;
    end else begin
      err_q <= err_d;
      err_src_q <= err_src_d;
    end
  end
  assign bus.err = err_q;
  assign bus.err_src = err_src_q;
`else
  assign ok = 1'b1;
  assign bus.err = 1'b0;
  assign bus.err_src = '0;
`endif
  assign bus.gnt = gnt_q;
  assign bus.io_we = we_q;
  assign bus.io_addr = addr_q;
  assign bus.io_datain = data_q;
endmodule

// File: tb/tb_io_write_arbiter.sv
// tb_io_write_arbiter: directed scoreboard bench for io_write_arbiter (both IO_WR_ADDR_CHECK_EN builds).
module tb_io_write_arbiter;
  typedef struct {
    logic [3:0]  g;
    logic        we;
    logic [31:0] a;
    logic [31:0] d;
    logic        e;
    logic [1:0]  es;
  } exp_t;
`ifdef IO_WR_ADDR_CHECK_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif
  logic io_clk = 1'b0;
  logic clr = 1'b1;
  logic [31:0] addr_v [4];
  logic [31:0] data_v [4];
  int checks = 0;
  int errors = 0;
  int cnt [4];
  exp_t q[$];
  io_write_arbiter_if #(.NREQ(4), .AW(32), .DW(32)) bus ();
  io_write_arbiter #(.NREQ(4), .AW(32), .DW(32), .NPORT(4)) dut (.io_clk(io_clk), .clr(clr), .bus(bus.slave));
  always #5 io_clk = ~io_clk;
  always_comb begin
    bus.req_addr = {addr_v[3], addr_v[2], addr_v[1], addr_v[0]};
    bus.req_data = {data_v[3], data_v[2], data_v[1], data_v[0]};
  end
  function automatic logic [31:0] a_of(input int i);
    return 32'h80 + 32'(4 * i);
  endfunction
  function automatic logic [31:0] d_of(input int i);
    return 32'hD000 + 32'(i);
  endfunction
  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, o, e);
    end
  endtask
  task automatic cyc(input logic [3:0] r, input logic c, input logic [3:0] g, input logic we,
                     input logic [31:0] a, input logic [31:0] d, input logic e, input logic [1:0] es);
    exp_t x;
    bus.req = r;
    clr = c;
    q.push_back('{g: g, we: we, a: a, d: d, e: e, es: es});
    @(negedge io_clk);
    x = q.pop_front();
    chk("gnt", 32'(bus.gnt), 32'(x.g));
    chk("io_we", 32'(bus.io_we), 32'(x.we));
    chk("io_addr", bus.io_addr, x.a);
    chk("io_datain", bus.io_datain, x.d);
    chk("err", 32'(bus.err), 32'(x.e));
    chk("err_src", 32'(bus.err_src), 32'(x.es));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end
  initial begin
    for (int i = 0; i < 4; i++) begin
      addr_v[i] = a_of(i);
      data_v[i] = d_of(i);
      cnt[i] = 0;
    end
    bus.req = 4'hF;
    for (int i = 0; i < 3; i++) cyc(4'hF, 1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    // Full contention from ptr 0, the first cycle right after reset release.
    for (int i = 0; i < 12; i++) begin
      cyc(4'hF, 1'b0, 4'b0001 << (i % 4), 1'b1, a_of(i % 4), d_of(i % 4), 1'b0, 2'd0);
      for (int k = 0; k < 4; k++) if (bus.gnt[k]) cnt[k]++;
    end
    for (int k = 0; k < 4; k++) chk($sformatf("grant_count_%0d", k), 32'(cnt[k]), 32'd3);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, a_of(3), d_of(3), 1'b0, 2'd0);
    addr_v[2] = 32'h80;
    data_v[2] = 32'h1234;
    for (int i = 0; i < 6; i++)
      cyc(4'b0100, 1'b0, (i % 2 == 0) ? 4'b0100 : 4'b0000, (i % 2 == 0), 32'h80, 32'h1234, 1'b0, 2'd0);
    addr_v[2] = a_of(2);
    data_v[2] = d_of(2);
    // ptr is now 3; requester 0 withdraws before the edge that would have granted it.
    bus.req = 4'b0011;
    #2;
    cyc(4'b0010, 1'b0, 4'b0010, 1'b1, a_of(1), d_of(1), 1'b0, 2'd0);
    cyc(4'hF, 1'b0, 4'b0100, 1'b1, a_of(2), d_of(2), 1'b0, 2'd0);
    cyc(4'hF, 1'b0, 4'b1000, 1'b1, a_of(3), d_of(3), 1'b0, 2'd0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, a_of(3), d_of(3), 1'b0, 2'd0);
    cyc(4'b0010, 1'b0, 4'b0010, 1'b1, a_of(1), d_of(1), 1'b0, 2'd0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, a_of(1), d_of(1), 1'b0, 2'd0);
    // ptr is 2 so requester 2 would win; reset at that edge must suppress it.
    cyc(4'b0101, 1'b1, 4'h0, 1'b0, 32'h0, 32'h0, 1'b0, 2'd0);
    cyc(4'b0101, 1'b0, 4'b0001, 1'b1, a_of(0), d_of(0), 1'b0, 2'd0);
    cyc(4'b0101, 1'b0, 4'b0100, 1'b1, a_of(2), d_of(2), 1'b0, 2'd0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, a_of(2), d_of(2), 1'b0, 2'd0);
    addr_v[1] = 32'h40;
    cyc(4'b0010, 1'b0, 4'b0010, !CK, 32'h40, d_of(1), CK, CK ? 2'd1 : 2'd0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, 32'h40, d_of(1), CK, CK ? 2'd1 : 2'd0);
    cyc(4'b1000, 1'b0, 4'b1000, 1'b1, a_of(3), d_of(3), CK, CK ? 2'd1 : 2'd0);
    cyc(4'h0, 1'b0, 4'h0, 1'b0, a_of(3), d_of(3), CK, CK ? 2'd1 : 2'd0);
    chk("scoreboard_empty", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
